// File: rtl/cordic_pkg.sv
// Shared widths, FSM state type and constant tables for the hyperbolic CORDIC engine.
// Pure definitions: no latency, no flow control.
package cordic_pkg;

  localparam int FRA_WIDTH = 16;
  localparam int INT_WIDTH = 3;
  localparam int DWIDTH    = 1 + INT_WIDTH + FRA_WIDTH;
  localparam int N_ITER    = 16;
  localparam int IW        = 6;
  localparam int LUT_FRA   = 16;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // atanh(2^-i) scaled by 2^LUT_FRA, rounded to nearest; zero from i=18 upward
  function automatic logic [31:0] atanh_lut(input logic [IW-1:0] i);
    logic [31:0] v;
    case (i)
      6'd1:    v = 32'd35999;
      6'd2:    v = 32'd16739;
      6'd3:    v = 32'd8235;
      6'd4:    v = 32'd4101;
      6'd5:    v = 32'd2049;
      6'd6:    v = 32'd1024;
      6'd7:    v = 32'd512;
      6'd8:    v = 32'd256;
      6'd9:    v = 32'd128;
      6'd10:   v = 32'd64;
      6'd11:   v = 32'd32;
      6'd12:   v = 32'd16;
      6'd13:   v = 32'd8;
      6'd14:   v = 32'd4;
      6'd15:   v = 32'd2;
      6'd16:   v = 32'd1;
      6'd17:   v = 32'd1;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  function automatic logic is_repeat(input logic [IW-1:0] i);
    return (i == 6'd4) || (i == 6'd13);
  endfunction

endpackage

// File: rtl/cordic_hyp_iter_if.sv
// Valid/ready bundle between range-reduction stage 2, the CORDIC engine and its consumer.
// master = upstream/downstream environment, slave = engine.
interface cordic_hyp_iter_if
  #(parameter int DWIDTH = cordic_pkg::DWIDTH);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DWIDTH-1:0] xin;
  logic signed [DWIDTH-1:0] yin;
  logic signed [DWIDTH-1:0] zin;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DWIDTH-1:0] xout;
  logic signed [DWIDTH-1:0] yout;
  logic signed [DWIDTH-1:0] zout;
  logic                     busy;

  modport master (
    output in_valid, xin, yin, zin, out_ready,
    input  in_ready, out_valid, xout, yout, zout, busy
  );

  modport slave (
    input  in_valid, xin, yin, zin, out_ready,
    output in_ready, out_valid, xout, yout, zout, busy
  );

endinterface

// File: rtl/cordic_hyp_micro.sv
// One hyperbolic micro-rotation, purely combinational (0 cycles, no flow control).
// CORDIC_SAT_EN: X/Y clip to +/-max on overflow; otherwise everything wraps. Z always wraps.
module cordic_hyp_micro
  #(parameter int DWIDTH = cordic_pkg::DWIDTH)
  (
  input  logic signed [DWIDTH-1:0]        x,
  input  logic signed [DWIDTH-1:0]        y,
  input  logic signed [DWIDTH-1:0]        z,
  input  logic        [cordic_pkg::IW-1:0] i,
  input  logic signed [DWIDTH-1:0]        atanh_k,
  output logic signed [DWIDTH-1:0]        xn,
  output logic signed [DWIDTH-1:0]        yn,
  output logic signed [DWIDTH-1:0]        zn
  );
  import cordic_pkg::*;

  logic                     neg;
  logic signed [DWIDTH-1:0] xs;
  logic signed [DWIDTH-1:0] ys;

  assign neg = z[DWIDTH-1];
  assign xs  = x >>> i;
  assign ys  = y >>> i;

`ifdef CORDIC_SAT_EN
  logic signed [DWIDTH:0] xw;
  logic signed [DWIDTH:0] yw;

  function automatic logic signed [DWIDTH-1:0] clip(input logic signed [DWIDTH:0] v);
    logic signed [DWIDTH-1:0] r;
    if (v[DWIDTH] != v[DWIDTH-1])
      r = v[DWIDTH] ? {1'b1, {(DWIDTH-1){1'b0}}} : {1'b0, {(DWIDTH-1){1'b1}}};
    else
      r = v[DWIDTH-1:0];
    return r;
  endfunction

  // one guard bit exposes the overflow the clip needs to see
  always_comb begin
    xw = neg ? ({x[DWIDTH-1], x} - {ys[DWIDTH-1], ys}) : ({x[DWIDTH-1], x} + {ys[DWIDTH-1], ys});
    yw = neg ? ({y[DWIDTH-1], y} - {xs[DWIDTH-1], xs}) : ({y[DWIDTH-1], y} + {xs[DWIDTH-1], xs});
    xn = clip(xw);
    yn = clip(yw);
  end
`else
  assign xn = neg ? (x - ys) : (x + ys);
  assign yn = neg ? (y - xs) : (y + xs);
`endif

  assign zn = neg ? (z + atanh_k) : (z - atanh_k);

endmodule

// File: rtl/cordic_hyp_iter.sv
// Iterative hyperbolic CORDIC: 18 cycles accept->out_valid at defaults; result held until out_ready,
// in_ready low while busy or while an unconsumed result sits in DONE. CORDIC_SAT_EN selects saturating X/Y.
module cordic_hyp_iter
  #(
  parameter int FRA_WIDTH = cordic_pkg::FRA_WIDTH,
  parameter int INT_WIDTH = cordic_pkg::INT_WIDTH,
  parameter int DWIDTH    = 1 + INT_WIDTH + FRA_WIDTH,
  parameter int N_ITER    = cordic_pkg::N_ITER
  )
  (
  input  logic              clk,
  input  logic              rst,
  cordic_hyp_iter_if.slave  bus
  );
  import cordic_pkg::*;

  state_t                   state;
  state_t                   state_nx;
  logic signed [DWIDTH-1:0] x_q, y_q, z_q;
  logic signed [DWIDTH-1:0] x_nx, y_nx, z_nx;
  logic signed [DWIDTH-1:0] xo_q, yo_q, zo_q;
  logic signed [DWIDTH-1:0] atanh_k;
  logic        [IW-1:0]     iter;
  logic                     rep_done;
  logic [31:0]              lut_raw;
  logic                     accept;
  logic                     rep_first;
  logic                     last_pass;
  logic                     busy_c;
  logic                     valid_c;

  assign lut_raw = atanh_lut(iter);
  assign atanh_k = (FRA_WIDTH >= LUT_FRA) ? DWIDTH'(lut_raw << (FRA_WIDTH - LUT_FRA))
                                          : DWIDTH'(lut_raw >> (LUT_FRA - FRA_WIDTH));

  cordic_hyp_micro #(.DWIDTH(DWIDTH)) u_micro (
    .x       (x_q),
    .y       (y_q),
    .z       (z_q),
    .i       (iter),
    .atanh_k (atanh_k),
    .xn      (x_nx),
    .yn      (y_nx),
    .zn      (z_nx)
  );

  assign bus.in_ready = !rst && ((state == IDLE) || ((state == DONE) && bus.out_ready));
  assign accept       = bus.in_valid && bus.in_ready;
  // the first visit to a repeat index keeps i; the second advances it
  assign rep_first    = is_repeat(iter) && !rep_done;
  assign last_pass    = (iter == IW'(N_ITER)) && !rep_first;

  always_comb begin
    state_nx = state;
    busy_c   = 1'b0;
    valid_c  = 1'b0;
    case (state)
      IDLE: if (accept) state_nx = RUN;
      RUN: begin
        busy_c = 1'b1;
        if (last_pass) state_nx = DONE;
      end
      DONE: begin
        valid_c = 1'b1;
        if (bus.out_ready) state_nx = accept ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      iter     <= '0;
      rep_done <= 1'b0;
      xo_q     <= '0;
      yo_q     <= '0;
      zo_q     <= '0;
    end else if (accept) begin
      x_q      <= bus.xin;
      y_q      <= bus.yin;
      z_q      <= bus.zin;
      iter     <= IW'(1);
      rep_done <= 1'b0;
    end else if (state == RUN) begin
      x_q <= x_nx;
      y_q <= y_nx;
      z_q <= z_nx;
      if (rep_first) begin
        rep_done <= 1'b1;
      end else begin
        rep_done <= 1'b0;
        iter     <= iter + 1'b1;
      end
      if (last_pass) begin
        xo_q <= x_nx;
        yo_q <= y_nx;
        zo_q <= z_nx;
      end
    end
  end

  assign bus.busy      = busy_c;
  assign bus.out_valid = valid_c;
  assign bus.xout      = xo_q;
  assign bus.yout      = yo_q;
  assign bus.zout      = zo_q;

endmodule

// File: tb/tb_cordic_hyp_iter.sv
// Bench for cordic_hyp_iter: directed cases plus randomized traffic, scored against a
// real-arithmetic reference of the rotation sequence and a cycle-level handshake model.
module tb_cordic_hyp_iter;

  localparam int  CYC  = 18;
  localparam int  DW   = 20;
  localparam longint MAXV = 524287;
  localparam longint MINV = -524288;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_hyp_iter_if #(.DWIDTH(DW)) bus();

  cordic_hyp_iter #(.FRA_WIDTH(16), .INT_WIDTH(3), .DWIDTH(DW), .N_ITER(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input logic signed [63:0] act,
                             input longint lo, input longint hi);
    n_checks++;
    if ($isunknown(act) || act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected within [%0d,%0d]", name, act, lo, hi);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint wrap(input longint v);
    logic signed [DW-1:0] t;
    t = v[DW-1:0];
    return longint'(t);
  endfunction

  function automatic longint clip(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  // atanh by its power series, scaled to 16 fractional bits, rounded to nearest
  function automatic longint atanh_ref(input int i);
    real x, p, s;
    x = 1.0;
    for (int k = 0; k < i; k++) x = x / 2.0;
    s = 0.0;
    p = x;
    for (int k = 0; k < 40; k++) begin
      s = s + p / real'(2 * k + 1);
      p = p * x * x;
    end
    return longint'($rtoi($floor(s * 65536.0 + 0.5)));
  endfunction

  task automatic ref_rot(input longint xi, input longint yi, input longint zi,
                         output longint xo, output longint yo, output longint zo);
    longint x, y, z, nx, ny;
    longint d;
    int shifts[$];
    for (int i = 1; i <= 16; i++) begin
      shifts.push_back(i);
      if (i == 4 || i == 13) shifts.push_back(i);
    end
    x = xi; y = yi; z = zi;
    foreach (shifts[k]) begin
      d  = (z >= 0) ? 1 : -1;
      nx = x + d * (y >>> shifts[k]);
      ny = y + d * (x >>> shifts[k]);
`ifdef CORDIC_SAT_EN
      x = clip(nx);
      y = clip(ny);
`else
      x = wrap(nx);
      y = wrap(ny);
`endif
      z = wrap(z - d * atanh_ref(shifts[k]));
    end
    xo = x; yo = y; zo = z;
  endtask

  // ---------------- per-cycle compare process ----------------
  bit     chk_en  = 1'b0;
  logic   m_busy  = 1'b0;
  logic   m_valid = 1'b0;
  int     m_left  = 0;
  longint m_x, m_y, m_z, n_x, n_y, n_z;

  always @(negedge clk) begin
    logic exp_rdy, acc, con;
    if (chk_en) begin
      exp_rdy = !rst && ((!m_busy && !m_valid) || (m_valid && bus.out_ready));
      check("in_ready", bus.in_ready, exp_rdy);
      check("busy", bus.busy, m_busy);
      check("out_valid", bus.out_valid, m_valid);
      if (m_valid) begin
        check("xout", bus.xout, m_x);
        check("yout", bus.yout, m_y);
        check("zout", bus.zout, m_z);
      end
      acc = bus.in_valid && exp_rdy;
      con = m_valid && bus.out_ready;
      if (rst) begin
        m_busy  = 1'b0;
        m_valid = 1'b0;
      end else begin
        if (m_busy) begin
          m_left--;
          if (m_left == 0) begin
            m_busy = 1'b0; m_valid = 1'b1;
            m_x = n_x; m_y = n_y; m_z = n_z;
          end
        end
        if (con) m_valid = 1'b0;
        if (acc) begin
          ref_rot(longint'(bus.xin), longint'(bus.yin), longint'(bus.zin), n_x, n_y, n_z);
          m_busy = 1'b1;
          m_left = CYC;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input longint x, input longint y, input longint z);
    bit ok;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.xin = x[DW-1:0]; bus.yin = y[DW-1:0]; bus.zin = z[DW-1:0];
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    check("accept_wait", ok, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.out_valid && n < 200);
    check("out_valid_wait", bus.out_valid, 1);
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    longint ex, ey, ez, rx, ry, rz, x, y, z;

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.xin = '0; bus.yin = '0; bus.zin = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_xout", bus.xout, 0);
    check("rst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);

    // model pinned by hand-computed values
    check("atanh_1", atanh_ref(1), 35999);
    check("atanh_4", atanh_ref(4), 4101);
    check("atanh_16", atanh_ref(16), 1);
    ref_rot(79134, 0, 32768, rx, ry, rz);
    check_range("model_cosh", rx, 73892, 73908);
    check_range("model_sinh", ry, 34142, 34158);

    // cosh/sinh of +0.5, then 10 cycles of backpressure
    send(79134, 0, 32768);
    wait_out(n);
    check("latency_pos", n, CYC);
    check_range("cosh_pos", bus.xout, 73892, 73908);
    check_range("sinh_pos", bus.yout, 34142, 34158);
    check_range("resid_pos", bus.zout, -4, 4);
    ref_rot(79134, 0, 32768, ex, ey, ez);
    repeat (10) begin
      @(posedge clk); #1;
      check("hold_xout", bus.xout, ex);
      check("hold_in_ready", bus.in_ready, 0);
      check("hold_valid", bus.out_valid, 1);
    end
    consume();
    check("idle_valid", bus.out_valid, 0);
    check("idle_in_ready", bus.in_ready, 1);
    check("idle_busy", bus.busy, 0);

    // -0.5, then back-to-back accept from DONE
    send(79134, 0, -32768);
    wait_out(n);
    check_range("cosh_neg", bus.xout, 73892, 73908);
    check_range("sinh_neg", bus.yout, -34158, -34142);
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    bus.xin = 20'sd79134; bus.yin = 20'sd0; bus.zin = 20'sd16384;
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    wait_out(n);
    check("latency_b2b", n, CYC);
    consume();

    // reset in the middle of RUN
    send(79134, 0, 32768);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_xout", bus.xout, 0);
    rst = 1'b0;

    // near-full-scale operands: wrap (or clip) behaviour
    send(longint'(20'h7FFF0), longint'(20'h7FFF0), 32768);
    wait_out(n);
    ref_rot(longint'(20'h7FFF0), longint'(20'h7FFF0), 32768, ex, ey, ez);
    check("big_xout", bus.xout, ex);
    check("big_yout", bus.yout, ey);
    consume();

    // randomized traffic, in-range and full-range, with ignored mid-run requests
    for (int t = 0; t < 40; t++) begin
      if (t % 5 == 4) begin
        x = longint'($urandom_range(0, 1048575)) - 524288;
        y = longint'($urandom_range(0, 1048575)) - 524288;
        z = longint'($urandom_range(0, 1048575)) - 524288;
      end else begin
        x = longint'($urandom_range(0, 262144)) - 131072;
        y = longint'($urandom_range(0, 262144)) - 131072;
        z = longint'($urandom_range(0, 146538)) - 73269;
      end
      send(x, y, z);
      if ($urandom_range(0, 1) == 1) begin
        bus.in_valid = 1'b1;
        bus.xin = 20'($urandom); bus.yin = 20'($urandom); bus.zin = 20'($urandom);
      end
      wait_out(n);
      bus.in_valid = 1'b0;
      check("latency_rand", n, CYC);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      consume();
    end

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
